mem_responder: RTL

//   Memory-side responder for the control unit's memory strobes (MARin, MDRin, Read, write_mem).

---
 rtl/mem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Memory-side responder for the control unit's memory strobes.
//            Holds MAR, MDR and a word-addressed RAM, and runs read/write
//            accesses with WAIT_CYCLES programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              write_mem,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mar_q,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int         c_depth   = 2 ** ADDR_W;
    // Counter reload: the accept cycle itself is not a wait state.
    localparam logic [3:0] c_wait_m1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_rwait = 2'd1;
    localparam logic [1:0] c_s_wwait = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [0:c_depth-1];

    logic              w_ready;
    logic              w_busy;
    logic              w_commit_rd;
    logic              w_commit_wr;
    logic              w_latch;
    logic              w_set_err;
    logic [ADDR_W-1:0] w_acc_addr;

    // Next-state, counter and access-commit decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_commit_rd = 1'b0;
        w_commit_wr = 1'b0;
        w_latch     = 1'b0;
        w_set_err   = 1'b0;
        w_acc_addr  = r_mar;
        case (r_state)
            c_s_idle: begin
                if (Read && write_mem) begin
                    w_set_err = 1'b1;
                end else if (Read || write_mem) begin
                    if (WAIT_CYCLES == 0) begin
                        // Single-cycle access straight from MAR
                        w_ready     = 1'b1;
                        w_commit_rd = Read;
                        w_commit_wr = write_mem;
                    end else begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = c_wait_m1;
                        w_state_nxt = Read ? c_s_rwait : c_s_wwait;
                    end
                end
            end
            c_s_rwait, c_s_wwait: begin
                w_busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    // Commit with the address captured at acceptance
                    w_ready     = 1'b1;
                    w_acc_addr  = r_addr;
                    w_commit_rd = (r_state == c_s_rwait);
                    w_commit_wr = (r_state == c_s_wwait);
                    w_state_nxt = c_s_idle;
                end
            end
            default: begin
                w_state_nxt = c_s_idle;
            end
        endcase
    end

    // State, counter, MAR/MDR/address latch and sticky error register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_s_idle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr <= r_mar;
            end
            if (MARin) begin
                r_mar <= bus_in[ADDR_W-1:0];
            end
            if (w_commit_rd) begin
                r_mdr <= r_mem[w_acc_addr];
            end else if (MDRin && !Read) begin
                r_mdr <= bus_in;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // RAM write port; contents survive reset but a write aborted by reset never lands
    always_ff @(posedge clk) begin
        if (!reset && w_commit_wr) begin
            r_mem[w_acc_addr] <= r_mdr;
        end
    end

    assign mdr_out   = r_mdr;
    assign mar_q     = r_mar;
    assign mem_ready = w_ready;
    assign busy      = w_busy;
    assign err       = r_err;

endmodule
`default_nettype wire
